rng_arbiter: RTL and testbench
==============================

Name: rng_arbiter

Overview:
- Owns a single 8-bit LFSR random source and shares it round-robin among N_REQ requesters, e.g. spawn, direction and power-up logic.
- Each requester asks for a value bounded by its own inclusive maximum.
- The bound is met by mask-and-reject sampling, with a deterministic fallback after MAX_TRIES rejections.
- Sits between the debounced reseed pulse and the game-object controllers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEED, 8'hA5, LFSR reset/reseed value; must be nonzero (SEED=0 is replaced by 8'h01).
- MAX_TRIES, 4, rejected samples allowed before fallback (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- reseed  input  1  synchronous pulse (already debounced); reloads LFSR with SEED
- req  input  N_REQ  per-requester request; held high until own rsp_valid
- req_max  input  8*N_REQ  inclusive upper bound per requester, slice i = [8i+7:8i]; stable while req high
- gnt  output  N_REQ  one-hot current owner; high from grant through RESP
- rsp_valid  output  N_REQ  one-cycle pulse to owner with result
- rsp_data  output  8  result; valid when any rsp_valid bit is high; holds last value otherwise
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=SEED, rr_ptr=0, tries=0.
  - gnt=0, rsp_valid=0, rsp_data=0, busy=0.
- LFSR:
  - Free-runs every clock after reset: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - reseed=1 loads SEED instead, overriding the advance that cycle.
  - reseed does not disturb arbitration state.
  - Sequence from 8'hA5: A5, 4A, 95, 2A, ...
- IDLE:
  - If req!=0, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch the winner index and its req_max, set gnt one-hot, tries=0, go to DRAW.
- DRAW (one sample per cycle):
  - mask = smallest all-ones value >= max (bit-smear of max); m = lfsr & mask.
  - m <= max: rsp_data<=m, go to RESP.
  - Otherwise tries++. If tries+1 == MAX_TRIES: rsp_data<=m-(max+1), go to RESP. Since m<=2*max+1, this result is always <=max.
  - Otherwise stay in DRAW.
  - Owner's req dropped: abort to IDLE, no rsp_valid, gnt=0, rr_ptr unchanged.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - rr_ptr <= (owner+1) mod N_REQ; gnt cleared on exit; go to IDLE.
- Latency:
  - Request seen at edge E0 → grant at E0, first sample at E1, rsp_valid high between E1 and E2 on an accept-first draw.
  - Each rejection adds one cycle; worst case is MAX_TRIES+1 cycles from grant to rsp_valid.
  - IDLE is always visited between grants, so back-to-back service costs one idle cycle.
- Boundaries:
  - max=0: mask 0, immediate accept with 0.
  - max=255: mask FF, always accepts.
  - Non-owner req changes mid-draw are ignored.
  - All req low: remain IDLE.
  - reseed during DRAW: the next sample uses SEED-derived values; the draw is not aborted.
  - rst_n low mid-operation: immediate return to reset values; no response pulse is ever emitted for the interrupted draw.

Test Plan:
- Fallback, reset, reseed and abort scenarios run with MAX_TRIES overridden to 1 for the fallback case.
- Simple draw: req[0]=1, max=8'hFF, asserted at reset release (IDLE at first edge) → gnt=0001; rsp_valid[0] pulse after second edge; rsp_data=8'h4A.
- Mask accept: same timing with max=8'h0F → rsp_data=8'h0A, latency 2 cycles.
- Rejection retry: max=8'h08 (mask 0F); sample 0x0A rejected, next 0x95&0F=0x05 accepted → rsp_data=8'h05, latency 3 cycles.
- Fallback: MAX_TRIES=1, max=8'h08 → 0x0A rejected, rsp_data=0x0A-9=8'h01 at latency 2.
- Round-robin: req=4'b1111, all max=FF, each requester drops req after its pulse → rsp_valid order 0,1,2,3; then req=4'b1001 → requester 0 served before 3; gnt never multi-hot.
- Abort and reset:
  - req[2] dropped during DRAW → no rsp_valid, busy=0 next cycle, rr_ptr unchanged.
  - rst_n pulsed low mid-DRAW → outputs 0 immediately, lfsr=A5.
  - reseed pulse → lfsr=A5 next cycle, then 4A.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: one 8-bit LFSR shared round-robin among N_REQ requesters.
// Each requester gets a value in [0, req_max] by mask-and-reject sampling,
// with a deterministic fold-down fallback after MAX_TRIES rejections.
//
//   state | meaning
//   IDLE  | no owner; pick the next requester from rr_ptr with wrap
//   DRAW  | one masked sample per cycle until accept, fallback or abort
//   RESP  | one-cycle rsp_valid pulse to the owner, then back to IDLE

module rng_arbiter #(
    parameter int         N_REQ     = 4,
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         MAX_TRIES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reseed,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_max,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_data,
    output logic               busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);
    // An all-zero LFSR would lock up, so a zero seed is nudged to 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      lfsr;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [7:0]      max_q;
    logic [TW-1:0]   tries;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [7:0]      pick_max;

    logic [7:0]      smear1;
    logic [7:0]      smear2;
    logic [7:0]      mask;
    logic [7:0]      sample;
    logic [7:0]      folded;
    logic            last_try;

    // Round-robin search: first set req bit at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_max   = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
                pick_max   = req_max[8*j +: 8];
            end
        end
    end

    // Bit-smear of the latched bound gives the tightest all-ones mask;
    // a rejected sample is at most 2*max+1, so subtracting max+1 folds it
    // back into range without a second draw.
    always_comb begin
        smear1   = max_q | (max_q >> 1);
        smear2   = smear1 | (smear1 >> 2);
        mask     = smear2 | (smear2 >> 4);
        sample   = lfsr & mask;
        folded   = sample - max_q - 8'd1;
        last_try = ((int'(tries) + 1) == MAX_TRIES);
    end

    assign busy = (state != IDLE);

    // Free-running LFSR; reseed reloads the seed and wins over the advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else if (reseed) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Arbitration and draw sequencing with registered grant/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            max_q     <= 8'h00;
            tries     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner           <= pick_idx;
                        max_q           <= pick_max;
                        tries           <= '0;
                        gnt             <= '0;
                        gnt[pick_idx]   <= 1'b1;
                        state           <= DRAW;
                    end
                end
                DRAW: begin
                    if (!req[owner]) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (sample <= max_q) begin
                        rsp_data         <= sample;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end else if (last_try) begin
                        rsp_data         <= folded;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                RESP: begin
                    gnt <= '0;
                    if (int'(owner) == N_REQ - 1) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= owner + 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter. Two instances share stimulus: dut0 with
// default MAX_TRIES, dut1 with MAX_TRIES=1 to exercise the fallback path.

module tb_rng_arbiter;

    logic        clk;
    logic        rst_n;
    logic        reseed;
    logic [3:0]  req;
    logic [31:0] req_max;
    logic [3:0]  gnt0, rv0, gnt1, rv1;
    logic [7:0]  rd0, rd1;
    logic        busy0, busy1;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    rng_arbiter #(.N_REQ(4), .SEED(8'hA5), .MAX_TRIES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .reseed(reseed), .req(req),
        .req_max(req_max), .gnt(gnt0), .rsp_valid(rv0), .rsp_data(rd0),
        .busy(busy0)
    );

    rng_arbiter #(.N_REQ(4), .SEED(8'hA5), .MAX_TRIES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .reseed(reseed), .req(req),
        .req_max(req_max), .gnt(gnt1), .rsp_valid(rv1), .rsp_data(rd1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for an edge, then release with the given request pattern so
    // that the next edge is E0 (grant edge).
    task automatic start_release(input logic [3:0] r, input logic [31:0] m);
        rst_n   = 1'b0;
        reseed  = 1'b0;
        req     = 4'b0000;
        req_max = m;
        @(posedge clk);
        #1;
        req   = r;
        rst_n = 1'b1;
    endtask

    // Count edges from E0 until each instance pulses; 0 means no pulse.
    task automatic wait_rsp(output int lat0, output logic [7:0] d0,
                            output int lat1, output logic [7:0] d1);
        lat0 = 0; lat1 = 0; d0 = 8'h00; d1 = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (lat0 == 0 && rv0 != 4'b0) begin lat0 = c; d0 = rd0; end
            if (lat1 == 0 && rv1 != 4'b0) begin lat1 = c; d1 = rd1; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reseed = 1'b0; req = 4'b0; req_max = 32'h0;
        tick();
        vecs++; if (gnt0 !== 4'b0) begin errs++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt0); end
        vecs++; if (rv0 !== 4'b0) begin errs++;
            $display("FAIL reset_rsp_valid: got %b expected 0000", rv0); end
        vecs++; if (rd0 !== 8'h00) begin errs++;
            $display("FAIL reset_rsp_data: got %h expected 00", rd0); end
        vecs++; if (busy0 !== 1'b0) begin errs++;
            $display("FAIL reset_busy: got %b expected 0", busy0); end
        vecs++; if (dut0.lfsr !== 8'hA5) begin errs++;
            $display("FAIL reset_lfsr: got %h expected a5", dut0.lfsr); end
    endtask

    task automatic test_simple();
        start_release(4'b0001, 32'h0000_00FF);
        tick();
        vecs++; if (gnt0 !== 4'b0001) begin errs++;
            $display("FAIL simple_gnt: got %b expected 0001", gnt0); end
        vecs++; if (busy0 !== 1'b1) begin errs++;
            $display("FAIL simple_busy: got %b expected 1", busy0); end
        vecs++; if (rv0 !== 4'b0000) begin errs++;
            $display("FAIL simple_early_rv: got %b expected 0000", rv0); end
        tick();
        vecs++; if (rv0 !== 4'b0001) begin errs++;
            $display("FAIL simple_rv: got %b expected 0001", rv0); end
        vecs++; if (rd0 !== 8'h4A) begin errs++;
            $display("FAIL simple_data: got %h expected 4a", rd0); end
        tick();
        vecs++; if (rv0 !== 4'b0000) begin errs++;
            $display("FAIL simple_rv_clear: got %b expected 0000", rv0); end
        vecs++; if (gnt0 !== 4'b0000) begin errs++;
            $display("FAIL simple_gnt_clear: got %b expected 0000", gnt0); end
        vecs++; if (rd0 !== 8'h4A) begin errs++;
            $display("FAIL simple_data_hold: got %h expected 4a", rd0); end
    endtask

    task automatic test_mask_accept();
        int l0, l1; logic [7:0] d0, d1;
        start_release(4'b0001, 32'h0000_000F);
        wait_rsp(l0, d0, l1, d1);
        vecs++; if (d0 !== 8'h0A) begin errs++;
            $display("FAIL mask_data: got %h expected 0a", d0); end
        vecs++; if (l0 !== 2) begin errs++;
            $display("FAIL mask_latency: got %0d expected 2", l0); end
    endtask

    task automatic test_retry_fallback();
        int l0, l1; logic [7:0] d0, d1;
        start_release(4'b0001, 32'h0000_0008);
        wait_rsp(l0, d0, l1, d1);
        vecs++; if (d0 !== 8'h05) begin errs++;
            $display("FAIL retry_data: got %h expected 05", d0); end
        vecs++; if (l0 !== 3) begin errs++;
            $display("FAIL retry_latency: got %0d expected 3", l0); end
        vecs++; if (d1 !== 8'h01) begin errs++;
            $display("FAIL fallback_data: got %h expected 01", d1); end
        vecs++; if (l1 !== 2) begin errs++;
            $display("FAIL fallback_latency: got %0d expected 2", l1); end
    endtask

    task automatic test_max_zero();
        int l0, l1; logic [7:0] d0, d1;
        start_release(4'b0001, 32'h0000_0000);
        wait_rsp(l0, d0, l1, d1);
        vecs++; if (l0 !== 2) begin errs++;
            $display("FAIL zero_latency: got %0d expected 2", l0); end
        vecs++; if (d0 !== 8'h00) begin errs++;
            $display("FAIL zero_data: got %h expected 00", d0); end
    endtask

    task automatic test_idle();
        start_release(4'b0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++; if (busy0 !== 1'b0 || gnt0 !== 4'b0) begin errs++;
                $display("FAIL idle_stay: got busy=%b gnt=%b expected 0 0000",
                         busy0, gnt0); end
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 2, 3, 0, 3};
        int idx, last_t, seen;
        start_release(4'b1111, 32'hFFFF_FFFF);
        last_t = 0;
        for (int n = 0; n < 6; n++) begin
            seen = 0;
            idx  = -1;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                tick();
                vecs++; if (!$onehot0(gnt0)) begin errs++;
                    $display("FAIL rr_gnt_onehot: got %b expected at most one bit",
                             gnt0); end
                if (rv0 != 4'b0) begin
                    seen = 1;
                    for (int b = 3; b >= 0; b--) if (rv0[b]) idx = b;
                    req = req & ~rv0;
                end
            end
            vecs++; if (idx !== exp_order[n]) begin errs++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", n, idx,
                         exp_order[n]); end
            if (n == 1 || n == 2 || n == 3) begin
                vecs++; if (cyc - last_t !== 3) begin errs++;
                    $display("FAIL rr_gap[%0d]: got %0d expected 3", n,
                             cyc - last_t); end
            end
            last_t = cyc;
            if (n == 3) req = 4'b1001;
        end
    endtask

    task automatic test_abort();
        int idx;
        start_release(4'b0100, 32'h0008_0000);
        tick();
        vecs++; if (gnt0 !== 4'b0100) begin errs++;
            $display("FAIL abort_gnt: got %b expected 0100", gnt0); end
        tick();
        vecs++; if (rv0 !== 4'b0000 || busy0 !== 1'b1) begin errs++;
            $display("FAIL abort_reject: got rv=%b busy=%b expected 0000 1",
                     rv0, busy0); end
        req = 4'b0000;
        tick();
        vecs++; if (busy0 !== 1'b0 || gnt0 !== 4'b0000) begin errs++;
            $display("FAIL abort_idle: got busy=%b gnt=%b expected 0 0000",
                     busy0, gnt0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (rv0 !== 4'b0000) begin errs++;
                $display("FAIL abort_no_rsp: got %b expected 0000", rv0); end
        end
        req_max = 32'hFFFF_FFFF;
        req     = 4'b1010;
        idx     = -1;
        for (int c = 0; c < 10 && idx < 0; c++) begin
            tick();
            if (rv0 != 4'b0) begin
                for (int b = 3; b >= 0; b--) if (rv0[b]) idx = b;
            end
        end
        vecs++; if (idx !== 1) begin errs++;
            $display("FAIL abort_rr_unchanged: got %0d expected 1", idx); end
    endtask

    task automatic test_reset_mid();
        start_release(4'b0001, 32'h0000_00FF);
        tick();
        tick();
        tick();
        tick();
        vecs++; if (busy0 !== 1'b1 || gnt0 !== 4'b0001) begin errs++;
            $display("FAIL mid_pre: got busy=%b gnt=%b expected 1 0001",
                     busy0, gnt0); end
        rst_n = 1'b0;
        #1;
        vecs++; if (gnt0 !== 4'b0 || busy0 !== 1'b0 || rv0 !== 4'b0) begin
            errs++;
            $display("FAIL mid_outputs: got gnt=%b busy=%b rv=%b expected 0",
                     gnt0, busy0, rv0); end
        vecs++; if (rd0 !== 8'h00) begin errs++;
            $display("FAIL mid_data: got %h expected 00", rd0); end
        vecs++; if (dut0.lfsr !== 8'hA5) begin errs++;
            $display("FAIL mid_lfsr: got %h expected a5", dut0.lfsr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (rv0 !== 4'b0000) begin errs++;
                $display("FAIL mid_no_rsp: got %b expected 0000", rv0); end
        end
        rst_n = 1'b1;
        req   = 4'b0000;
    endtask

    task automatic test_reseed();
        start_release(4'b0000, 32'h0);
        tick();
        vecs++; if (dut0.lfsr !== 8'h4A) begin errs++;
            $display("FAIL reseed_run1: got %h expected 4a", dut0.lfsr); end
        tick();
        vecs++; if (dut0.lfsr !== 8'h95) begin errs++;
            $display("FAIL reseed_run2: got %h expected 95", dut0.lfsr); end
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        vecs++; if (dut0.lfsr !== 8'hA5) begin errs++;
            $display("FAIL reseed_load: got %h expected a5", dut0.lfsr); end
        vecs++; if (busy0 !== 1'b0) begin errs++;
            $display("FAIL reseed_busy: got %b expected 0", busy0); end
        tick();
        vecs++; if (dut0.lfsr !== 8'h4A) begin errs++;
            $display("FAIL reseed_next: got %h expected 4a", dut0.lfsr); end
    endtask

    initial begin
        rst_n = 1'b0; reseed = 1'b0; req = 4'b0; req_max = 32'h0;
        test_reset();
        test_simple();
        test_mask_accept();
        test_retry_fallback();
        test_max_zero();
        test_idle();
        test_round_robin();
        test_abort();
        test_reset_mid();
        test_reseed();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
